data_memory_model: RTL and testbench

DATA_MEMORY_MODEL -- requirements
Module: data_memory_model

---
 rtl/data_memory_model.sv | 142 ++++++++++++++
 tb/tb_data_memory_model.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_model.sv
// data_memory_model
//   Word-addressed behavioural data memory with byte-masked writes, a
//   fully pipelined read path of configurable latency, a backdoor loader
//   port and saturating access counters.
//
// Parameters
//   DATA_WIDTH   data bus width in bits (32 or 64)
//   DEPTH_LOG2   log2 of the number of words
//   READ_LATENCY cycles from read acceptance to read_valid (1..8)
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   address        byte address; offset bits below the word size are ignored
//   read_enable    read request, accepted every cycle it is high
//   write_enable   write request, accepted every cycle it is high
//   write_data     write data
//   byte_enables   per-byte write mask
//   read_data      read result, zero whenever read_valid is low
//   read_valid     one pulse per accepted read
//   error          one pulse per out-of-range access or read/write collision
//   bd_write       backdoor full-word write strobe (honoured during reset)
//   bd_address     backdoor word index
//   bd_data        backdoor write data
//   read_count     accepted reads, saturating
//   write_count    committed port writes, saturating
module data_memory_model #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             address,
  input  logic                    read_enable,
  input  logic                    write_enable,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] byte_enables,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_valid,
  output logic                    error,
  input  logic                    bd_write,
  input  logic [DEPTH_LOG2-1:0]   bd_address,
  input  logic [DATA_WIDTH-1:0]   bd_data,
  output logic [31:0]             read_count,
  output logic [31:0]             write_count
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int HI    = OFF_W + DEPTH_LOG2;
  localparam int WORDS = 1 << DEPTH_LOG2;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  out_of_range;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_commit;
  logic                  wr_err;
  logic                  unused_addr_bits;

  // Any address bit above the word index marks the access out of range.
  assign word_idx         = address[OFF_W +: DEPTH_LOG2];
  assign out_of_range     = |(address >> HI);
  assign unused_addr_bits = ^address[OFF_W-1:0];

  // A simultaneous write wins; the read is dropped and flagged.
  assign rd_acc    = read_enable & ~write_enable & ~rst;
  assign wr_acc    = write_enable & ~rst;
  assign wr_commit = wr_acc & ~out_of_range;
  assign wr_err    = wr_acc & (out_of_range | read_enable);

  // Storage: backdoor assignment comes last so it overrides a port write
  // to the same word in the same cycle.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (byte_enables[b]) begin
          mem[word_idx][b*8 +: 8] <= write_data[b*8 +: 8];
        end
      end
    end
    if (bd_write) begin
      mem[bd_address] <= bd_data;
    end
  end

  logic [READ_LATENCY-1:0] vld_p;
  logic [READ_LATENCY-1:0] rerr_p;
  logic [DATA_WIDTH-1:0]   rdata_p [READ_LATENCY];
  logic                    werr_p0;

  // Stage 0: sample memory at the accepting edge (pre-write contents);
  // later stages are a plain shift toward the output.
  always_ff @(posedge clk) begin
    rdata_p[0] <= (rd_acc && !out_of_range) ? mem[word_idx] : '0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rdata_p[i] <= rdata_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p   <= '0;
      rerr_p  <= '0;
      werr_p0 <= 1'b0;
    end else begin
      vld_p[0]  <= rd_acc;
      rerr_p[0] <= rd_acc & out_of_range;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        rerr_p[i] <= rerr_p[i-1];
      end
      werr_p0 <= wr_err;
    end
  end

  // Output stage
  assign read_valid = vld_p[READ_LATENCY-1];
  assign read_data  = vld_p[READ_LATENCY-1] ? rdata_p[READ_LATENCY-1] : '0;
  assign error      = werr_p0 | rerr_p[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (rd_acc) begin
        read_count <= sat_inc(read_count);
      end
      if (wr_commit) begin
        write_count <= sat_inc(write_count);
      end
    end
  end

endmodule

// File: tb/tb_data_memory_model.sv
module tb_data_memory_model;

  localparam int DW = 32;
  localparam int L  = 3;

  logic          clk;
  logic          rst;
  logic [31:0]   address;
  logic          read_enable;
  logic          write_enable;
  logic [DW-1:0] write_data;
  logic [3:0]    byte_enables;
  logic [DW-1:0] read_data;
  logic          read_valid;
  logic          error;
  logic          bd_write;
  logic [15:0]   bd_address;
  logic [DW-1:0] bd_data;
  logic [31:0]   read_count;
  logic [31:0]   write_count;

  data_memory_model #(
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(16),
    .READ_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .read_enable(read_enable),
    .write_enable(write_enable),
    .write_data(write_data),
    .byte_enables(byte_enables),
    .read_data(read_data),
    .read_valid(read_valid),
    .error(error),
    .bd_write(bd_write),
    .bd_address(bd_address),
    .bd_data(bd_data),
    .read_count(read_count),
    .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rd_exp_t;

  rd_exp_t     rq[$];
  int          eq[$];
  logic [31:0] mmem [int];
  int          rcnt;
  int          wcnt;
  int          cyc;
  int          checks;
  int          failures;
  logic        mon_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int idx);
    return mmem.exists(idx) ? mmem[idx] : 32'hxxxx_xxxx;
  endfunction

  // One clock of stimulus; the reference model is updated and expectations
  // are queued for the edge that accepts these inputs.
  task automatic drive(input logic r, input logic re_i, input logic we_i,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic bw,
                       input logic [15:0] ba, input logic [31:0] bdv);
    logic        oor;
    int          idx;
    logic [31:0] w;
    rd_exp_t     e;
    @(negedge clk);
    rst = r; read_enable = re_i; write_enable = we_i; address = a;
    write_data = wd; byte_enables = be; bd_write = bw; bd_address = ba; bd_data = bdv;
    oor = (a[31:18] != 14'd0);
    idx = int'(a[17:2]);
    if (r) begin
      rcnt = 0;
      wcnt = 0;
    end else begin
      if (re_i && !we_i) begin
        rcnt++;
        e.due  = cyc + L;
        e.data = oor ? 32'd0 : mem_rd(idx);
        e.err  = oor;
        rq.push_back(e);
      end
      if (we_i) begin
        if (!oor) begin
          wcnt++;
          w = mem_rd(idx);
          for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
          mmem[idx] = w;
        end
        if (oor || re_i) eq.push_back(cyc + 1);
      end
    end
    if (bw) mmem[int'(ba)] = bdv;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 16'd0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b0, 1'b1, 1'b0, a, 32'd0, 4'd0, 1'b0, 16'd0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(1'b0, 1'b0, 1'b1, a, d, be, 1'b0, 16'd0, 32'd0);
  endtask

  task automatic bd_rst(input logic [15:0] ba, input logic [31:0] d);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, ba, d);
  endtask

  task automatic check_counts(input string tag);
    idle();
    chk({tag, " read_count"}, {32'd0, read_count}, {32'd0, 32'(rcnt)});
    chk({tag, " write_count"}, {32'd0, write_count}, {32'd0, 32'(wcnt)});
  endtask

  // Monitor: every cycle compares read_valid, read_data and error against
  // the queued expectations due in this cycle.
  always @(negedge clk) begin
    logic        exp_vld;
    logic        exp_err;
    logic [31:0] exp_data;
    rd_exp_t     e;
    if (mon_en) begin
      exp_vld = 1'b0; exp_err = 1'b0; exp_data = 32'd0;
      while (rq.size() > 0 && rq[0].due < cyc) begin
        e = rq.pop_front();
        chk("late_read_valid", 64'd0, 64'd1);
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e = rq.pop_front();
        exp_vld = 1'b1; exp_data = e.data; exp_err = e.err;
      end
      while (eq.size() > 0 && eq[0] <= cyc) begin
        if (eq[0] == cyc) exp_err = 1'b1;
        void'(eq.pop_front());
      end
      chk("read_valid", {63'd0, read_valid}, {63'd0, exp_vld});
      chk("read_data", {32'd0, read_data}, {32'd0, exp_data});
      chk("error", {63'd0, error}, {63'd0, exp_err});
    end
  end

  initial begin
    checks = 0; failures = 0; rcnt = 0; wcnt = 0; cyc = 0; mon_en = 1'b0;
    rst = 1'b1; read_enable = 1'b0; write_enable = 1'b0; address = 32'd0;
    write_data = 32'd0; byte_enables = 4'd0; bd_write = 1'b0;
    bd_address = 16'd0; bd_data = 32'd0;

    // Reset with backdoor preload; a read request during reset is ignored.
    bd_rst(16'd5, 32'hDEADBEEF);
    drive(1'b1, 1'b1, 1'b0, 32'h14, 32'd0, 4'd0, 1'b1, 16'd0, 32'h11223344);
    bd_rst(16'd1, 32'h01010101);
    bd_rst(16'd2, 32'h22222222);
    bd_rst(16'd3, 32'h33333333);
    bd_rst(16'd4, 32'h44444444);
    mon_en = 1'b1;
    check_counts("reset");

    // Backdoor-loaded word read through the port.
    rd(32'h14);
    repeat (L) idle();
    check_counts("bd_read");

    // Byte-masked write followed immediately by a read of the same word.
    wr(32'h0, 32'hAABBCCDD, 4'b0101);
    rd(32'h0);
    repeat (L) idle();
    check_counts("byte_mask");

    // Back-to-back reads of words 0..3.
    rd(32'h0); rd(32'h4); rd(32'h8); rd(32'hC);
    repeat (L + 1) idle();

    // Out-of-range write, memory check, out-of-range read.
    wr(32'h0004_0000, 32'hFFFF_FFFF, 4'hF);
    rd(32'h0);
    rd(32'h0004_0000);
    repeat (L) idle();
    check_counts("oor");

    // Read/write collision on word 2.
    drive(1'b0, 1'b1, 1'b1, 32'h8, 32'h55667788, 4'hF, 1'b0, 16'd0, 32'd0);
    idle();
    rd(32'h8);
    repeat (L) idle();
    check_counts("collision");

    // Read sees pre-edge contents when a backdoor write lands the same edge.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0, 1'b1, 16'd4, 32'h99999999);
    rd(32'h10);

    // Backdoor beats a port write to the same word.
    drive(1'b0, 1'b0, 1'b1, 32'h18, 32'h12345678, 4'hF, 1'b1, 16'd6, 32'hCAFEF00D);
    rd(32'h18);

    // Empty byte mask still counts as a write and leaves data unchanged.
    wr(32'h14, 32'h0, 4'h0);
    rd(32'h14);
    repeat (L) idle();
    check_counts("mask_zero");

    // Two consecutive offending writes give two consecutive error pulses.
    wr(32'h8000_0000, 32'h1, 4'hF);
    wr(32'h0010_0000, 32'h2, 4'hF);
    repeat (L + 2) idle();
    check_counts("err_pair");

    // Reset while reads are in flight: their results must never appear.
    rd(32'h0);
    rd(32'h4);
    rq.delete();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 16'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 16'd0, 32'd0);
    check_counts("flush");
    repeat (L + 3) idle();

    for (int i = 0; i < 50 && (rq.size() > 0 || eq.size() > 0); i++) idle();
    chk("drain_pending", 64'(rq.size() + eq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
